shift_right_seq: RTL and testbench
==================================

// Module: shift_right_seq
// PURPOSE
//  Multicycle right shifter: the opposite direction of the datapath's fixed <<2 shifter.
//  Executes SRL/SRA (and word-index recovery, i.e. >>2) over several cycles, STEP bits per cycle.
//  Sits beside the ALU in the multicycle datapath, started by the control unit in EXE.
//  The control unit holds in EXE until Done, then latches DataOut into the ALU-out register.
// PARAMETERS
//  WIDTH    32  data width; must be a power of two
//  SHAMT_W  5   shift-amount width; must equal log2(WIDTH)
//  STEP     1   bit positions shifted per SHIFT cycle; legal range 1..WIDTH-1
// PORTS
//  CLK      in   1        rising-edge clock
//  Reset    in   1        synchronous, active-high reset
//  Start    in   1        request; sampled only when Busy=0
//  DataIn   in   WIDTH    operand, captured on accepted Start
//  Shamt    in   SHAMT_W  shift amount, captured on accepted Start
//  Arith    in   1        0 = logical (zero fill); 1 = arithmetic (fill with DataIn[WIDTH-1])
//  Busy     out  1        1 while a shift is in progress (state SHIFT)
//  Done     out  1        single-cycle pulse: DataOut is valid
//  DataOut  out  WIDTH    result; holds its value until the next accepted Start completes
// BEHAVIOUR
//  Reset (CLK edge with Reset=1):
//   - State goes to IDLE.
//   - Busy=0, Done=0, DataOut=0; internal operand, count and fill registers cleared.
//   - Reset overrides Start and aborts any shift in progress; no Done is produced for it.
//  States: IDLE, SHIFT, DONE. Busy=1 only in SHIFT. Done=1 only in DONE.
//  Accept: Start=1 at a clock edge while in IDLE or DONE.
//   - Captures DataIn, Shamt and Arith; fill bit = Arith & DataIn[WIDTH-1].
//   - Shamt=0 -> next state DONE.
//   - Otherwise -> next state SHIFT with remaining count = Shamt.
//  SHIFT: each cycle shifts the working register right by n = min(STEP, remaining) and
//   inserts n fill bits at the MSB end; remaining -= n. When remaining reaches 0 -> DONE.
//  DataOut: updated from the working register on the edge that enters DONE, so it is valid
//   during the whole DONE cycle and is held afterwards.
//  DONE: lasts one cycle. Start=1 -> accepted (back-to-back operation); otherwise -> IDLE.
//  Start while in SHIFT is ignored and is not queued.
//  Latency: Start accepted at edge of cycle T -> Done=1 in cycle T+1+ceil(Shamt/STEP).
//   - Shamt=0: Done in cycle T+1, DataOut = DataIn.
//  Captured operands are unaffected by changes on DataIn/Shamt/Arith after acceptance.
//  Result equals DataIn >> Shamt (logical) or $signed(DataIn) >>> Shamt (arithmetic),
//   for every Shamt in 0..WIDTH-1. No overflow or exception outputs.
// TESTING
//  1. Reset=1 for 2 cycles, then Start with DataIn=32'h0000_0040, Shamt=2, Arith=0, STEP=1
//     -> Busy=1 for 2 cycles; Done in cycle T+3; DataOut=32'h0000_0010.
//  2. DataIn=32'h8000_0000, Shamt=31: Arith=1 -> DataOut=32'hFFFF_FFFF;
//     Arith=0 -> DataOut=32'h0000_0001. Done in cycle T+32 (STEP=1).
//  3. Shamt=0, DataIn=32'hDEAD_BEEF -> Busy never rises; Done in cycle T+1; DataOut=32'hDEAD_BEEF.
//  4. Start while Busy (second op DataIn=32'h1, Shamt=1) -> ignored; only the first result appears.
//     Then Start during the DONE cycle -> accepted; its Done follows with no idle gap.
//  5. Reset asserted mid-SHIFT -> next cycle Busy=0, Done=0, DataOut=0;
//     no Done is seen for the aborted operation.
//  6. STEP=4, DataIn=32'hF000_0000, Shamt=7, Arith=1 -> 2 SHIFT cycles (4, then 3);
//     DataOut=32'hFFE0_0000.
//     Also: random regression vs a reference model, all Shamt values, both Arith settings.

Source files
------------

// File: rtl/shift_right_seq.sv
// -----------------------------------------------------------------------------
// shift_right_seq
//   Multicycle right shifter (SRL / SRA / >>2 word-index recovery) that sits
//   beside the ALU. It consumes up to STEP bit positions per SHIFT cycle, so a
//   shift by Shamt takes ceil(Shamt/STEP) SHIFT cycles plus one DONE cycle.
//
// Ports
//   CLK         in   1        rising-edge clock
//   Reset       in   1        synchronous, active-high reset
//   Start       in   1        request, sampled only while Busy=0 (IDLE or DONE)
//   DataIn      in   WIDTH    operand, captured on an accepted Start
//   Shamt       in   SHAMT_W  shift amount, captured on an accepted Start
//   Arith       in   1        0 = logical (zero fill), 1 = arithmetic (sign fill)
//   Busy        out  1        high while in SHIFT
//   Done        out  1        one-cycle pulse, DataOut valid
//   DataOut     out  WIDTH    result, held until the next operation completes
//   o_dbg_state out  2        current FSM state (IDLE=0, SHIFT=1, DONE=2)
//
// Handshake: a request is accepted on any rising edge where Start=1 and the
// block is in IDLE or DONE (Busy=0). While Busy=1 Start is ignored and never
// queued. Done is high for exactly one cycle per accepted request, and in that
// cycle a new Start is accepted, giving back-to-back operation with no gap.
// -----------------------------------------------------------------------------
module shift_right_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   DataIn,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   DataOut,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  state_t             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_fill;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_dataout;

  logic [SHAMT_W-1:0] w_n;
  logic [SHAMT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0]   w_work_sh;

  // Final step may be shorter than STEP when the remaining count is smaller.
  assign w_n       = (r_cnt < STEP_C) ? r_cnt : STEP_C;
  assign w_cnt_nxt = r_cnt - w_n;

  // Ones-fill is done by shifting the complement and inverting back, which
  // inserts exactly w_n ones at the MSB end without a variable-width mask.
  assign w_work_sh = r_fill ? ~((~r_work) >> w_n) : (r_work >> w_n);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_cnt     <= '0;
      r_fill    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataout <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            r_work <= DataIn;
            r_cnt  <= Shamt;
            r_fill <= Arith & DataIn[WIDTH-1];
            if (Shamt == '0) begin
              // Zero shift skips SHIFT entirely; the operand is the result.
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_dataout <= DataIn;
            end else begin
              r_state <= S_SHIFT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_work <= w_work_sh;
          r_cnt  <= w_cnt_nxt;
          if (w_cnt_nxt == '0) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_dataout <= w_work_sh;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign DataOut     = r_dataout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_shift_right_seq.sv
`timescale 1ns/1ps
// Bench for shift_right_seq: one instance with STEP=1 and one with STEP=4,
// driven from the same stimulus signals. Expected results come from a
// reference function built on the language's own >> / >>> operators and a
// closed-form latency of 1 + ceil(Shamt/STEP).
module tb_shift_right_seq;

  logic        CLK;
  logic        Reset;
  logic        Start;
  logic [31:0] DataIn;
  logic [4:0]  Shamt;
  logic        Arith;

  logic        busy1, done1, busy4, done4;
  logic [31:0] dout1, dout4;
  logic [1:0]  st1, st4;

  int n_tests;
  int n_fail;

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .DataIn(DataIn), .Shamt(Shamt),
    .Arith(Arith), .Busy(busy1), .Done(done1), .DataOut(dout1), .o_dbg_state(st1)
  );

  shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .DataIn(DataIn), .Shamt(Shamt),
    .Arith(Arith), .Busy(busy4), .Done(done4), .DataOut(dout4), .o_dbg_state(st4)
  );

  // ---------------------------------------------------------------- clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- model
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input bit a);
    logic signed [31:0] sd;
    logic [31:0] r;
    sd = d;
    if (a) r = sd >>> s;
    else   r = d >> s;
    return r;
  endfunction

  function automatic int ref_lat(input int s, input int step);
    return 1 + (s + step - 1) / step;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  // Present a request for one edge, then scramble the inputs so that any
  // dependence on them after acceptance shows up as a wrong result.
  task automatic start_op(input logic [31:0] d, input logic [4:0] s, input bit a);
    Start  = 1'b1;
    DataIn = d;
    Shamt  = s;
    Arith  = a;
    @(posedge CLK); #1;
    Start  = 1'b0;
    DataIn = $urandom;
    Shamt  = 5'($urandom_range(0, 31));
    Arith  = 1'($urandom_range(0, 1));
  endtask

  // Called in the first cycle after the accepting edge (k=1). Returns lat=0
  // if Done never appears within the budget.
  task automatic wait_done(input bit sel4, output int lat, output int nbusy,
                           output logic [31:0] got);
    bit seen;
    lat = 0; nbusy = 0; got = '0; seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      if (sel4 ? done4 : done1) begin
        seen = 1'b1;
        lat  = k;
        got  = sel4 ? dout4 : dout1;
      end else begin
        if (sel4 ? busy4 : busy1) nbusy++;
        @(posedge CLK); #1;
      end
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; DataIn = '0; Shamt = '0; Arith = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    n_tests++;
    if ({busy1, done1, dout1} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_dut1: busy=%0b done=%0b dout=%h, want 0 0 00000000", busy1, done1, dout1);
    end
    n_tests++;
    if ({busy4, done4, dout4} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_dut4: busy=%0b done=%0b dout=%h, want 0 0 00000000", busy4, done4, dout4);
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic;
    int lat, nb;
    logic [31:0] got;
    start_op(32'h0000_0040, 5'd2, 1'b0);
    wait_done(1'b0, lat, nb, got);
    n_tests++;
    if (lat !== 3 || nb !== 2 || got !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL basic: lat=%0d busy=%0d dout=%h, want lat=3 busy=2 dout=00000010", lat, nb, got);
    end
    idle(40);
  endtask

  task automatic test_extremes;
    int lat, nb;
    logic [31:0] got;
    start_op(32'h8000_0000, 5'd31, 1'b1);
    wait_done(1'b0, lat, nb, got);
    n_tests++;
    if (lat !== 32 || got !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL sra31: lat=%0d dout=%h, want lat=32 dout=ffffffff", lat, got);
    end
    idle(2);
    start_op(32'h8000_0000, 5'd31, 1'b0);
    wait_done(1'b0, lat, nb, got);
    n_tests++;
    if (lat !== 32 || got !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL srl31: lat=%0d dout=%h, want lat=32 dout=00000001", lat, got);
    end
    idle(40);
  endtask

  task automatic test_zero_shamt;
    int lat, nb;
    logic [31:0] got;
    start_op(32'hDEAD_BEEF, 5'd0, 1'b1);
    wait_done(1'b0, lat, nb, got);
    n_tests++;
    if (lat !== 1 || nb !== 0 || got !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL zero_shamt: lat=%0d busy=%0d dout=%h, want lat=1 busy=0 dout=deadbeef", lat, nb, got);
    end
    idle(40);
  endtask

  task automatic test_back_to_back;
    int lat, nb, stray;
    logic [31:0] got;
    // First op: 0x80 >> 3, SHIFT in k=1..3, DONE at k=4.
    start_op(32'h0000_0080, 5'd3, 1'b0);
    // Intruding request during SHIFT; must be dropped.
    Start = 1'b1; DataIn = 32'h1; Shamt = 5'd1; Arith = 1'b0;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(1'b0, lat, nb, got);
    n_tests++;
    if (lat !== 3 || got !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL ignore_busy: lat_after=%0d dout=%h, want lat_after=3 dout=00000010", lat, got);
    end
    // Now in the DONE cycle: issue the next op immediately.
    start_op(32'h0000_00F0, 5'd4, 1'b0);
    wait_done(1'b0, lat, nb, got);
    n_tests++;
    if (lat !== 5 || nb !== 4 || got !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL back_to_back: lat=%0d busy=%0d dout=%h, want lat=5 busy=4 dout=0000000f", lat, nb, got);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (done1) stray++;
    end
    n_tests++;
    if (stray !== 0 || dout1 !== 32'h0000_000F) begin
      n_fail++;
      $display("FAIL no_stray_done: extra_done=%0d dout=%h, want 0 and 0000000f held", stray, dout1);
    end
    idle(40);
  endtask

  task automatic test_reset_abort;
    int stray;
    start_op(32'hFFFF_FFFF, 5'd20, 1'b1);
    idle(3);
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    n_tests++;
    if ({busy1, done1, dout1} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_abort: busy=%0b done=%0b dout=%h, want 0 0 00000000", busy1, done1, dout1);
    end
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (done1 || busy1) stray++;
    end
    n_tests++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: activity_cycles=%0d, want 0", stray);
    end
  endtask

  task automatic test_step4;
    int lat, nb;
    logic [31:0] got;
    start_op(32'hF000_0000, 5'd7, 1'b1);
    wait_done(1'b1, lat, nb, got);
    n_tests++;
    if (lat !== 3 || nb !== 2 || got !== 32'hFFE0_0000) begin
      n_fail++;
      $display("FAIL step4: lat=%0d busy=%0d dout=%h, want lat=3 busy=2 dout=ffe00000", lat, nb, got);
    end
    idle(40);
  endtask

  task automatic test_random(input bit sel4);
    int lat, nb, s, step;
    bit a;
    logic [31:0] d, got, exp_v;
    step = sel4 ? 4 : 1;
    for (int i = 0; i < 80; i++) begin
      s = (i < 64) ? (i % 32) : int'($urandom_range(0, 31));
      a = (i < 64) ? bit'(i / 32) : bit'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[31] = 1'b1;
      exp_v = ref_shift(d, s, a);
      start_op(d, 5'(s), a);
      wait_done(sel4, lat, nb, got);
      n_tests++;
      if (got !== exp_v || lat !== ref_lat(s, step)) begin
        n_fail++;
        $display("FAIL random_step%0d: d=%h s=%0d a=%0b dout=%h lat=%0d, want %h lat=%0d",
                 step, d, s, a, got, lat, exp_v, ref_lat(s, step));
      end
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(40);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_zero_shamt();
    test_back_to_back();
    test_reset_abort();
    test_step4();
    test_random(1'b0);
    test_random(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
